// File: rtl/ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the RV32I pipelined control unit.
//   - RV32I base opcode constants
//   - encodings for the ALU A-operand select, immediate format and
//     write-back source
//   - the per-stage control words (EX, MEM, WB) and their bubble values
// No ports; imported by ctrl_decode and ctrl_pipe.
// ---------------------------------------------------------------------------
package ctrl_pipe_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU code used for every address / pass-through computation
    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } asel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // Fields consumed only by the execute stage
    typedef struct packed {
        logic     valid;
        logic [3:0] alu_sel;
        asel_e    asel;
        logic     bsel;
        imm_sel_e imm_sel;
        logic     branch;
        logic     jump;
    } ex_ctrl_t;

    // Fields consumed by the memory stage
    typedef struct packed {
        logic valid;
        logic rd_en;
        logic wr_en;
    } mem_ctrl_t;

    // Fields consumed by write-back
    typedef struct packed {
        logic       valid;
        logic       reg_wen;
        wb_sel_e    sel;
        logic [4:0] rd;
    } wb_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '{
        valid:   1'b0,
        alu_sel: 4'd0,
        asel:    ASEL_RS1,
        bsel:    1'b0,
        imm_sel: IMM_I,
        branch:  1'b0,
        jump:    1'b0
    };

    localparam mem_ctrl_t MEM_BUBBLE = '{
        valid: 1'b0,
        rd_en: 1'b0,
        wr_en: 1'b0
    };

    localparam wb_ctrl_t WB_BUBBLE = '{
        valid:   1'b0,
        reg_wen: 1'b0,
        sel:     WB_ALU,
        rd:      5'd0
    };

endpackage

// File: rtl/ctrl_pipe_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational RV32I instruction decoder. Produces the full control
// word split into EX / MEM / WB structs, plus register-usage information for
// the load-use hazard check.
// Ports:
//   inst_i      in  32  instruction to decode
//   ex_o        out     EX control fields (valid = 1 for a known opcode)
//   mem_o       out     MEM control fields
//   wb_o        out     WB control fields (reg_wen suppressed for rd = x0)
//   illegal_o   out 1   opcode is not an RV32I base opcode
//   uses_rs1_o  out 1   instruction reads rs1
//   uses_rs2_o  out 1   instruction reads rs2
//   rs1_o       out 5   rs1 field
//   rs2_o       out 5   rs2 field
//   rd_o        out 5   rd field
// ---------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [31:0] inst_i,
    output ex_ctrl_t    ex_o,
    output mem_ctrl_t   mem_o,
    output wb_ctrl_t    wb_o,
    output logic        illegal_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = inst_i[6:0];
    assign funct3    = inst_i[14:12];
    assign funct7_b5 = inst_i[30];
    assign rs1_o     = inst_i[19:15];
    assign rs2_o     = inst_i[24:20];
    assign rd_o      = inst_i[11:7];

    // Remaining funct7 bits do not influence any RV32I control field.
    logic unused_funct7;
    assign unused_funct7 = ^{inst_i[31], inst_i[29:25]};

    // Start every word as a valid "nothing" instruction and let each opcode
    // switch on exactly the fields it needs. Unknown opcodes fall back to
    // the bubble values so they travel down the pipe as no-ops.
    always_comb begin
        ex_o        = EX_BUBBLE;
        mem_o       = MEM_BUBBLE;
        wb_o        = WB_BUBBLE;
        ex_o.valid  = 1'b1;
        mem_o.valid = 1'b1;
        wb_o.valid  = 1'b1;
        wb_o.rd     = rd_o;
        illegal_o   = 1'b0;
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                ex_o.alu_sel = {funct7_b5, funct3};
                wb_o.reg_wen = 1'b1;
                uses_rs1_o   = 1'b1;
                uses_rs2_o   = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only the shift-right pair uses funct7[5] (srli/srai);
                // for the other immediates bit 30 is part of the constant.
                ex_o.alu_sel = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_I;
                wb_o.reg_wen = 1'b1;
                uses_rs1_o   = 1'b1;
            end
            OPC_LOAD: begin
                ex_o.alu_sel = ALU_ADD;
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_I;
                mem_o.rd_en  = 1'b1;
                wb_o.reg_wen = 1'b1;
                wb_o.sel     = WB_MEM;
                uses_rs1_o   = 1'b1;
            end
            OPC_STORE: begin
                ex_o.alu_sel = ALU_ADD;
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_S;
                mem_o.wr_en  = 1'b1;
                uses_rs1_o   = 1'b1;
                uses_rs2_o   = 1'b1;
            end
            OPC_BRANCH: begin
                ex_o.alu_sel = {1'b0, funct3};
                ex_o.imm_sel = IMM_B;
                ex_o.branch  = 1'b1;
                uses_rs1_o   = 1'b1;
                uses_rs2_o   = 1'b1;
            end
            OPC_JAL: begin
                ex_o.alu_sel = ALU_ADD;
                ex_o.asel    = ASEL_PC;
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_J;
                ex_o.jump    = 1'b1;
                wb_o.reg_wen = 1'b1;
                wb_o.sel     = WB_PC4;
            end
            OPC_JALR: begin
                ex_o.alu_sel = ALU_ADD;
                ex_o.asel    = ASEL_RS1;
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_I;
                ex_o.jump    = 1'b1;
                wb_o.reg_wen = 1'b1;
                wb_o.sel     = WB_PC4;
                uses_rs1_o   = 1'b1;
            end
            OPC_LUI: begin
                ex_o.alu_sel = ALU_ADD;
                ex_o.asel    = ASEL_ZERO;
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_U;
                wb_o.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                ex_o.alu_sel = ALU_ADD;
                ex_o.asel    = ASEL_PC;
                ex_o.bsel    = 1'b1;
                ex_o.imm_sel = IMM_U;
                wb_o.reg_wen = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
                ex_o      = EX_BUBBLE;
                mem_o     = MEM_BUBBLE;
                wb_o      = WB_BUBBLE;
            end
        endcase

        // Writes to x0 are architecturally discarded; suppressing them here
        // keeps the register file and forwarding logic from seeing them.
        if (rd_o == 5'd0) begin
            wb_o.reg_wen = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
// Pipelined RV32I control unit. Decodes the instruction in the decode slot
// and carries its control word through EX, MEM and (N_STAGE-2) further
// stages, the last of which is WB. Detects load-use hazards and supports a
// branch flush and a global hold.
// Parameters:
//   N_STAGE        control pipeline depth (3..5); stage 1 = EX, 2 = MEM,
//                  N_STAGE = WB
// Ports:
//   clk_i, rst_i   clock (rising edge), synchronous active-high reset
//   inst_i         instruction in decode, qualified by inst_valid_i
//   hold_i         freeze every stage
//   flush_i        drop the instruction in decode
//   stall_o        load-use hazard, upstream must hold inst_i (comb.)
//   illegal_o      valid instruction with unknown opcode (comb.)
//   ex_*           EX stage control fields
//   mem_*          MEM stage control fields
//   wb_*           WB stage control fields
// ---------------------------------------------------------------------------
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int N_STAGE = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        inst_valid_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        illegal_o,
    output logic        ex_valid_o,
    output logic [3:0]  ex_alu_sel_o,
    output logic [1:0]  ex_asel_o,
    output logic        ex_bsel_o,
    output logic [2:0]  ex_imm_sel_o,
    output logic        ex_branch_o,
    output logic        ex_jump_o,
    output logic        mem_valid_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic        wb_valid_o,
    output logic        wb_reg_wen_o,
    output logic [1:0]  wb_sel_o,
    output logic [4:0]  wb_rd_o
);

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    ex_ctrl_t   dec_ex;
    mem_ctrl_t  dec_mem;
    wb_ctrl_t   dec_wb;
    logic       dec_illegal;
    logic       dec_uses_rs1;
    logic       dec_uses_rs2;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;

    ctrl_decode u_decode (
        .inst_i     (inst_i),
        .ex_o       (dec_ex),
        .mem_o      (dec_mem),
        .wb_o       (dec_wb),
        .illegal_o  (dec_illegal),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd)
    );

    assign illegal_o = inst_valid_i & dec_illegal;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    // EX holds the whole word (its own fields plus the ones it forwards)
    // and a private rd copy used only by the hazard comparator.
    ex_ctrl_t   ex_q,     ex_d;
    mem_ctrl_t  ex_mem_q, ex_mem_d;
    wb_ctrl_t   ex_wb_q,  ex_wb_d;
    logic [4:0] ex_rd_q,  ex_rd_d;

    // MEM keeps only MEM and WB fields.
    mem_ctrl_t  mem_q,    mem_d;
    wb_ctrl_t   mem_wb_q, mem_wb_d;

    // Load-use hazard: a load sitting in EX will not have its data until
    // after MEM, so a dependent instruction in decode must wait one cycle.
    // Loads into x0 never create a dependency.
    always_comb begin
        stall_o = 1'b0;
        if (inst_valid_i && ex_q.valid && ex_mem_q.rd_en && (ex_rd_q != 5'd0)) begin
            stall_o = (dec_uses_rs1 && (dec_rs1 == ex_rd_q)) ||
                      (dec_uses_rs2 && (dec_rs2 == ex_rd_q));
        end
    end

    // Next-state for EX and MEM. Hold freezes everything; otherwise MEM
    // always advances and EX takes either the decoded word or a bubble.
    // Flush and stall both inject a bubble, so their relative priority
    // only matters upstream (flush means the instruction is discarded).
    always_comb begin
        ex_d     = ex_q;
        ex_mem_d = ex_mem_q;
        ex_wb_d  = ex_wb_q;
        ex_rd_d  = ex_rd_q;
        mem_d    = mem_q;
        mem_wb_d = mem_wb_q;

        if (!hold_i) begin
            mem_d    = ex_mem_q;
            mem_wb_d = ex_wb_q;

            if (flush_i || stall_o || !inst_valid_i || dec_illegal) begin
                ex_d     = EX_BUBBLE;
                ex_mem_d = MEM_BUBBLE;
                ex_wb_d  = WB_BUBBLE;
                ex_rd_d  = 5'd0;
            end else begin
                ex_d     = dec_ex;
                ex_mem_d = dec_mem;
                ex_wb_d  = dec_wb;
                ex_rd_d  = dec_rd;
            end
        end
    end

    // EX and MEM registers; reset flushes both stages to bubbles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q     <= EX_BUBBLE;
            ex_mem_q <= MEM_BUBBLE;
            ex_wb_q  <= WB_BUBBLE;
            ex_rd_q  <= 5'd0;
            mem_q    <= MEM_BUBBLE;
            mem_wb_q <= WB_BUBBLE;
        end else begin
            ex_q     <= ex_d;
            ex_mem_q <= ex_mem_d;
            ex_wb_q  <= ex_wb_d;
            ex_rd_q  <= ex_rd_d;
            mem_q    <= mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // -----------------------------------------------------------------------
    // Carry stages 3..N_STAGE: only the WB fields remain. wb_link[s] is the
    // output of stage s; wb_link[2] is the MEM stage's WB fields.
    // -----------------------------------------------------------------------
    wb_ctrl_t wb_link [2:N_STAGE];

    assign wb_link[2] = mem_wb_q;

    for (genvar s = 3; s <= N_STAGE; s++) begin : g_wb
        wb_ctrl_t stage_q;
        wb_ctrl_t stage_d;

        // Advance from the previous stage unless the pipe is held.
        always_comb begin
            stage_d = stage_q;
            if (!hold_i) begin
                stage_d = wb_link[s-1];
            end
        end

        // Carry-stage register, cleared to a bubble on reset.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_q <= WB_BUBBLE;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign wb_link[s] = stage_q;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ex_valid_o   = ex_q.valid;
    assign ex_alu_sel_o = ex_q.alu_sel;
    assign ex_asel_o    = ex_q.asel;
    assign ex_bsel_o    = ex_q.bsel;
    assign ex_imm_sel_o = ex_q.imm_sel;
    assign ex_branch_o  = ex_q.branch;
    assign ex_jump_o    = ex_q.jump;

    assign mem_valid_o  = mem_q.valid;
    assign mem_rd_en_o  = mem_q.rd_en;
    assign mem_wr_en_o  = mem_q.wr_en;

    assign wb_valid_o   = wb_link[N_STAGE].valid;
    assign wb_reg_wen_o = wb_link[N_STAGE].reg_wen;
    assign wb_sel_o     = wb_link[N_STAGE].sel;
    assign wb_rd_o      = wb_link[N_STAGE].rd;

endmodule
